sobel_scan_ctrl: RTL and testbench

- Parametrised scan controller for the Sobel edge detector.
- Takes runtime image dimensions and walks a KxK window across the image in raster order.
- Sequences the window-buffer reads, the gradient calculation and the result write-back using req/done handshakes; the sub-blocks themselves are outside this block.
- Replaces the fixed 3x3, single-pass controller. Adds runtime dimensions, shift-versus-refill read scheduling, abort, parameter error reporting and output coordinates.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_scan_counter.sv | 40 ++++
 rtl/sobel_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sobel_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel scan controller.
package sobel_pkg;

  localparam int unsigned K_DEFAULT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoadParam,
    StFill,
    StCalc,
    StWrite,
    StAdvance,
    StShiftCol,
    StDone
  } scan_state_e;

  // Pixel reads for one image: full fill at each window row, one column per later step.
  function automatic int unsigned reads_per_image(input int unsigned k, input int unsigned w,
                                                  input int unsigned h);
    if (w < k || h < k) return 0;
    return (h - k + 1) * (k * k + (w - k) * k);
  endfunction

endpackage

// File: rtl/sobel_scan_counter.sv
// Window top-left position registers with end-of-row / end-of-image compares.
module sobel_scan_counter import sobel_pkg::*; #(
  parameter int unsigned K     = K_DEFAULT,
  parameter int unsigned DIM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_x,
  input  logic             inc_y,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] img_h,
  output logic [DIM_W-1:0] win_x,
  output logic [DIM_W-1:0] win_y,
  output logic             more_x,
  output logic             more_y
);

  localparam logic [DIM_W:0] KE = (DIM_W + 1)'(K);

  // One extra bit so win + K cannot wrap near the top of the coordinate range.
  assign more_x = ({1'b0, win_x} + KE) < {1'b0, img_w};
  assign more_y = ({1'b0, win_y} + KE) < {1'b0, img_h};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x <= '0;
      win_y <= '0;
    end else if (clr) begin
      win_x <= '0;
      win_y <= '0;
    end else if (inc_x) begin
      win_x <= win_x + DIM_W'(1);
    end else if (inc_y) begin
      win_x <= '0;
      win_y <= win_y + DIM_W'(1);
    end
  end

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster-order KxK window scan controller: sequences window reads, gradient calc and write-back.
module sobel_scan_ctrl import sobel_pkg::*; #(
  parameter int unsigned K      = K_DEFAULT,
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned SLOT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic              rd_req,
  output logic [DIM_W-1:0]  rd_x,
  output logic [DIM_W-1:0]  rd_y,
  output logic [SLOT_W-1:0] rd_slot,
  input  logic              rd_done,
  output logic              win_shift,
  output logic              calc_req,
  input  logic              calc_done,
  output logic              wr_req,
  output logic [DIM_W-1:0]  wr_x,
  output logic [DIM_W-1:0]  wr_y,
  input  logic              wr_done,
  output logic              busy,
  output logic              image_done,
  output logic              param_err
);

  localparam int unsigned    IDX_W = $clog2(K);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);
  localparam logic [DIM_W:0]   KE   = (DIM_W + 1)'(K);

  scan_state_e      state;
  logic [DIM_W-1:0] w_lat, h_lat, win_x, win_y;
  logic [IDX_W-1:0] rd_col, rd_row;
  logic             more_x, more_y, dims_bad;
  logic             cnt_clr, cnt_inc_x, cnt_inc_y;

  assign dims_bad  = ({1'b0, w_lat} < KE) || ({1'b0, h_lat} < KE);
  assign cnt_clr   = (state == StLoadParam);
  assign cnt_inc_x = (state == StAdvance) && more_x && !abort;
  assign cnt_inc_y = (state == StAdvance) && !more_x && more_y && !abort;

  sobel_scan_counter #(
    .K    (K),
    .DIM_W(DIM_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc_x (cnt_inc_x),
    .inc_y (cnt_inc_y),
    .img_w (w_lat),
    .img_h (h_lat),
    .win_x (win_x),
    .win_y (win_y),
    .more_x(more_x),
    .more_y(more_y)
  );

  // Addresses are decoded from registered state and forced to zero while no request is open.
  assign rd_x    = rd_req ? win_x + DIM_W'(rd_col) : '0;
  assign rd_y    = rd_req ? win_y + DIM_W'(rd_row) : '0;
  assign rd_slot = rd_req ? SLOT_W'(rd_col) * SLOT_W'(K) + SLOT_W'(rd_row) : '0;
  assign wr_x    = wr_req ? win_x + DIM_W'(K / 2) : '0;
  assign wr_y    = wr_req ? win_y + DIM_W'(K / 2) : '0;

  assign win_shift  = (state == StAdvance) && more_x;
  assign image_done = (state == StDone);
  assign busy       = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      w_lat     <= '0;
      h_lat     <= '0;
      rd_col    <= '0;
      rd_row    <= '0;
      rd_req    <= 1'b0;
      calc_req  <= 1'b0;
      wr_req    <= 1'b0;
      param_err <= 1'b0;
    end else begin
      param_err <= 1'b0;
      if (abort && state != StIdle) begin
        state    <= StIdle;
        rd_req   <= 1'b0;
        calc_req <= 1'b0;
        wr_req   <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              w_lat <= img_w;
              h_lat <= img_h;
              state <= StLoadParam;
            end
          end
          StLoadParam: begin
            if (dims_bad) begin
              param_err <= 1'b1;
              state     <= StIdle;
            end else begin
              rd_col <= '0;
              rd_row <= '0;
              rd_req <= 1'b1;
              state  <= StFill;
            end
          end
          // A shift-column pass starts with rd_col at LAST, so it ends after one column.
          StFill, StShiftCol: begin
            if (rd_done) begin
              if (rd_row != LAST) begin
                rd_row <= rd_row + IDX_W'(1);
              end else begin
                rd_row <= '0;
                if (rd_col != LAST) begin
                  rd_col <= rd_col + IDX_W'(1);
                end else begin
                  rd_req   <= 1'b0;
                  calc_req <= 1'b1;
                  state    <= StCalc;
                end
              end
            end
          end
          StCalc: begin
            if (calc_done) begin
              calc_req <= 1'b0;
              wr_req   <= 1'b1;
              state    <= StWrite;
            end
          end
          StWrite: begin
            if (wr_done) begin
              wr_req <= 1'b0;
              state  <= StAdvance;
            end
          end
          StAdvance: begin
            rd_row <= '0;
            if (more_x) begin
              rd_col <= LAST;
              rd_req <= 1'b1;
              state  <= StShiftCol;
            end else if (more_y) begin
              rd_col <= '0;
              rd_req <= 1'b1;
              state  <= StFill;
            end else begin
              state <= StDone;
            end
          end
          StDone:  state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Self-checking bench: scan model feeds read/write scoreboards, table of image runs plus corner cases.
module tb_sobel_scan_ctrl;
  import sobel_pkg::*;

  localparam int unsigned K      = 3;
  localparam int          KI     = 3;
  localparam int unsigned DIM_W  = 10;
  localparam int unsigned SLOT_W = 6;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [DIM_W-1:0]  img_w, img_h;
  logic              rd_req, rd_done, win_shift, calc_req, calc_done, wr_req, wr_done;
  logic [DIM_W-1:0]  rd_x, rd_y, wr_x, wr_y;
  logic [SLOT_W-1:0] rd_slot;
  logic              busy, image_done, param_err;

  always #5 clk = ~clk;

  sobel_scan_ctrl #(
    .K     (K),
    .DIM_W (DIM_W),
    .SLOT_W(SLOT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .img_w     (img_w),
    .img_h     (img_h),
    .rd_req    (rd_req),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_slot   (rd_slot),
    .rd_done   (rd_done),
    .win_shift (win_shift),
    .calc_req  (calc_req),
    .calc_done (calc_done),
    .wr_req    (wr_req),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_done   (wr_done),
    .busy      (busy),
    .image_done(image_done),
    .param_err (param_err)
  );

  typedef struct packed {
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic [SLOT_W-1:0] slot;
  } txn_t;

  typedef struct {
    int w;
    int h;
    bit tie;
    int dly;
    int exp_rd;
    int exp_wr;
    int exp_shift;
    int exp_perr;
    int exp_done;
  } vec_t;

  txn_t rd_q[$];
  txn_t wr_q[$];
  txn_t e;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd, n_calc, n_wr, n_shift, n_done, n_perr;
  bit tie = 1'b1;
  int max_dly = 0;
  bit hold_calc = 1'b0;
  bit stray_calc = 1'b0;

  int               rd_wait, calc_wait, wr_wait;
  logic             p_rd, p_rd_dn, p_wr, p_wr_dn;
  logic [DIM_W-1:0] p_rx, p_ry, p_wx, p_wy;
  logic [SLOT_W-1:0] p_rs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int pick();
    return tie ? 0 : int'($urandom_range(max_dly, 0));
  endfunction

  // Independent scan model: full K*K fill at column 0 of each window row, one column after.
  task automatic build_model(input int w, input int h);
    txn_t t;
    rd_q.delete();
    wr_q.delete();
    if (w < KI || h < KI) return;
    for (int wy = 0; wy <= h - KI; wy++) begin
      for (int wx = 0; wx <= w - KI; wx++) begin
        for (int c = 0; c < KI; c++) begin
          if (wx == 0 || c == KI - 1) begin
            for (int r = 0; r < KI; r++) begin
              t.x = DIM_W'(wx + c);
              t.y = DIM_W'(wy + r);
              t.slot = SLOT_W'(c * KI + r);
              rd_q.push_back(t);
            end
          end
        end
        t.x = DIM_W'(wx + KI / 2);
        t.y = DIM_W'(wy + KI / 2);
        t.slot = '0;
        wr_q.push_back(t);
      end
    end
  endtask

  task automatic clear_counts();
    n_rd = 0; n_calc = 0; n_wr = 0; n_shift = 0; n_done = 0; n_perr = 0;
  endtask

  // Responder and monitor: outputs sampled and done inputs driven on the falling edge.
  initial begin
    rd_done = 1'b0; calc_done = 1'b0; wr_done = 1'b0;
    rd_wait = 0; calc_wait = 0; wr_wait = 0;
    p_rd = 1'b0; p_rd_dn = 1'b0; p_wr = 1'b0; p_wr_dn = 1'b0;
    p_rx = '0; p_ry = '0; p_rs = '0; p_wx = '0; p_wy = '0;
    clear_counts();
    forever begin
      @(negedge clk);
      if (p_rd && !p_rd_dn && rd_req)
        check("rd_addr_stable", 32'({rd_x, rd_y, rd_slot}), 32'({p_rx, p_ry, p_rs}));
      if (p_wr && !p_wr_dn && wr_req)
        check("wr_addr_stable", 32'({wr_x, wr_y}), 32'({p_wx, p_wy}));
      if (win_shift) n_shift++;
      if (image_done) n_done++;
      if (param_err) n_perr++;
      if (tie) begin
        rd_done = 1'b1; calc_done = 1'b1; wr_done = 1'b1;
      end else begin
        rd_done = rd_req && rd_wait == 0;
        if (rd_req && rd_wait > 0) rd_wait--;
        calc_done = calc_req && calc_wait == 0 && !hold_calc;
        if (calc_req && calc_wait > 0) calc_wait--;
        wr_done = wr_req && wr_wait == 0;
        if (wr_req && wr_wait > 0) wr_wait--;
      end
      if (stray_calc) calc_done = 1'b1;
      if (!abort && !rst) begin
        if (rd_req && rd_done) begin
          n_rd++;
          rd_wait = pick();
          if (rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd_unexpected: got read (%0d,%0d) slot %0d, expected none",
                     rd_x, rd_y, rd_slot);
          end else begin
            e = rd_q.pop_front();
            check("rd_xy_slot", 32'({rd_x, rd_y, rd_slot}), 32'({e.x, e.y, e.slot}));
          end
        end
        if (calc_req && calc_done) begin
          n_calc++;
          calc_wait = pick();
        end
        if (wr_req && wr_done) begin
          n_wr++;
          wr_wait = pick();
          if (wr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL wr_unexpected: got write (%0d,%0d), expected none", wr_x, wr_y);
          end else begin
            e = wr_q.pop_front();
            check("wr_xy", 32'({wr_x, wr_y}), 32'({e.x, e.y}));
          end
        end
      end
      p_rd = rd_req; p_rd_dn = rd_done; p_rx = rd_x; p_ry = rd_y; p_rs = rd_slot;
      p_wr = wr_req; p_wr_dn = wr_done; p_wx = wr_x; p_wy = wr_y;
    end
  end

  task automatic pulse_start(input int w, input int h);
    @(posedge clk); #1;
    img_w = DIM_W'(w);
    img_h = DIM_W'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_image(input vec_t v);
    bit valid;
    valid = (v.exp_perr == 0);
    build_model(v.w, v.h);
    tie = v.tie;
    max_dly = v.dly;
    clear_counts();
    pulse_start(v.w, v.h);
    check("start_to_busy", 32'(busy), 32'(1));
    check("rd_req_early", 32'(rd_req), 32'(0));
    @(posedge clk); #1;
    check("start_to_rd_req", 32'(rd_req), 32'(valid));
    check("param_err_timing", 32'(param_err), 32'(!valid));
    for (int i = 0; i < 5000 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("image_finished", 32'(busy), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("reads", 32'(n_rd), 32'(v.exp_rd));
    check("reads_formula", 32'(n_rd), reads_per_image(K, v.w, v.h));
    check("calcs", 32'(n_calc), 32'(v.exp_wr));
    check("writes", 32'(n_wr), 32'(v.exp_wr));
    check("win_shifts", 32'(n_shift), 32'(v.exp_shift));
    check("param_err_pulses", 32'(n_perr), 32'(v.exp_perr));
    check("image_done_pulses", 32'(n_done), 32'(v.exp_done));
    check("rd_model_left", 32'(rd_q.size()), 32'(0));
    check("wr_model_left", 32'(wr_q.size()), 32'(0));
  endtask

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{w: 5, h: 4, tie: 1, dly: 0, exp_rd: 30, exp_wr: 6, exp_shift: 4,
                exp_perr: 0, exp_done: 1};
    vecs[1] = '{w: 3, h: 3, tie: 1, dly: 0, exp_rd: 9, exp_wr: 1, exp_shift: 0,
                exp_perr: 0, exp_done: 1};
    vecs[2] = '{w: 2, h: 8, tie: 1, dly: 0, exp_rd: 0, exp_wr: 0, exp_shift: 0,
                exp_perr: 1, exp_done: 0};
    vecs[3] = '{w: 6, h: 5, tie: 0, dly: 5, exp_rd: 54, exp_wr: 12, exp_shift: 9,
                exp_perr: 0, exp_done: 1};
    vecs[4] = '{w: 7, h: 3, tie: 0, dly: 3, exp_rd: 21, exp_wr: 5, exp_shift: 4,
                exp_perr: 0, exp_done: 1};
    vecs[5] = '{w: 0, h: 5, tie: 1, dly: 0, exp_rd: 0, exp_wr: 0, exp_shift: 0,
                exp_perr: 1, exp_done: 0};
    vecs[6] = '{w: 3, h: 2, tie: 1, dly: 0, exp_rd: 0, exp_wr: 0, exp_shift: 0,
                exp_perr: 1, exp_done: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; img_w = '0; img_h = '0;
    #12;
    check("reset_ctl", 32'({rd_req, calc_req, wr_req, win_shift, busy, image_done, param_err}),
          32'(0));
    check("reset_coord", 32'({rd_x, rd_y, rd_slot}), 32'(0));
    check("reset_wr_coord", 32'({wr_x, wr_y}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Abort while idle must not start anything.
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'(0));

    for (int i = 0; i < 7; i++) run_image(vecs[i]);

    // Abort on the 5th read of the second window row.
    build_model(5, 4);
    tie = 1'b1;
    clear_counts();
    pulse_start(5, 4);
    for (int i = 0; i < 200 && n_rd < 19; i++) begin
      @(posedge clk); #1;
    end
    check("abort_point_reads", 32'(n_rd), 32'(19));
    check("abort_point_addr", 32'({rd_req, rd_x, rd_y, rd_slot}),
          32'({1'b1, DIM_W'(1), DIM_W'(2), SLOT_W'(4)}));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'({busy, rd_req, calc_req, wr_req}), 32'(0));
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done), 32'(0));
    check("abort_reads", 32'(n_rd), 32'(19));
    run_image(vecs[0]);

    // Reset in the middle of a calculation, then a stray calc_done.
    build_model(5, 4);
    tie = 1'b0;
    max_dly = 0;
    hold_calc = 1'b1;
    clear_counts();
    pulse_start(5, 4);
    for (int i = 0; i < 100 && !calc_req; i++) begin
      @(posedge clk); #1;
    end
    check("calc_reached", 32'(calc_req), 32'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_ctl", 32'({rd_req, calc_req, wr_req, win_shift, busy, image_done,
                              param_err}), 32'(0));
    check("rst_mid_coord", 32'({rd_x, rd_y, rd_slot}), 32'(0));
    check("rst_mid_wr_coord", 32'({wr_x, wr_y}), 32'(0));
    hold_calc = 1'b0;
    stray_calc = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    stray_calc = 1'b0;
    check("stray_calc_ignored", 32'({busy, calc_req, wr_req}), 32'(0));
    check("stray_calc_no_write", 32'(n_wr), 32'(0));
    run_image(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
